// File: rtl/spi_dac8512_pkg.sv
// Shared types and sizing for the DAC8512 receive-side model.
// Default frame width, FSM state encoding and bit counter sizing.
package spi_dac8512_pkg;

   localparam int NBIT_DEF = 12;

   typedef enum logic {
      IDLE,
      SHIFT
   } state_e;

   // Counter must hold 0..NBIT+1 so an over-long frame stays distinguishable.
   function automatic int cntWidth(input int nbit);
      return $clog2(nbit + 2);
   endfunction

   localparam int CNT_W = cntWidth(NBIT_DEF);

endpackage

// File: rtl/spi_dac8512_rx_sync_edge.sv
// Multi-stage synchronizer for one asynchronous input, followed by
// rise/fall detection against the previous synchronized sample.
module sync_edge #(
   parameter int NSYNC = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic async_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic [NSYNC-1:0] sync_q;
   logic             prev_q;

   // Stages reset to the inactive (high) level so no edge appears out of reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= '1;
         prev_q <= 1'b1;
      end else begin
         sync_q <= {sync_q[NSYNC-2:0], async_i};
         prev_q <= sync_q[NSYNC-1];
      end
   end

   assign level_o = sync_q[NSYNC-1];
   assign rise_o  = sync_q[NSYNC-1] & ~prev_q;
   assign fall_o  = ~sync_q[NSYNC-1] & prev_q;

endmodule

// File: rtl/spi_dac8512_rx.sv
// DAC8512 receive-side model: reassembles MSB-first serial frames into the
// input register and emulates the DAC register with load and clear.
module spi_dac8512_rx
   import spi_dac8512_pkg::*;
#(
   parameter int NBIT  = NBIT_DEF,
   parameter int NSYNC = 2
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            ncs_i,
   input  logic            sclk_i,
   input  logic            sdat_i,
   input  logic            nld_i,
   input  logic            nclr_i,
   output logic [NBIT-1:0] ireg_o,
   output logic [NBIT-1:0] do_o,
   output logic            frm_ok_o,
   output logic            frm_err_o,
   output logic            ld_done_o,
   output logic            busy_o
);

   localparam int            CW       = cntWidth(NBIT);
   localparam logic [CW-1:0] CNT_FULL = CW'(NBIT);
   localparam logic [CW-1:0] CNT_SAT  = CW'(NBIT + 1);

   logic ncsLvl, ncsRise, ncsFall;
   logic sclkLvlUnused, sclkRise, sclkFallUnused;
   logic sdatLvl, sdatRiseUnused, sdatFallUnused;
   logic nldLvlUnused, nldRiseUnused, nldFall;
   logic nclrLvl, nclrRiseUnused, nclrFallUnused;
   logic ncsLvlUnused;

   sync_edge #(.NSYNC(NSYNC)) uSyncNcs (
      .clk_i(clk_i), .rst_ni(rst_ni), .async_i(ncs_i),
      .level_o(ncsLvl), .rise_o(ncsRise), .fall_o(ncsFall)
   );
   sync_edge #(.NSYNC(NSYNC)) uSyncSclk (
      .clk_i(clk_i), .rst_ni(rst_ni), .async_i(sclk_i),
      .level_o(sclkLvlUnused), .rise_o(sclkRise), .fall_o(sclkFallUnused)
   );
   sync_edge #(.NSYNC(NSYNC)) uSyncSdat (
      .clk_i(clk_i), .rst_ni(rst_ni), .async_i(sdat_i),
      .level_o(sdatLvl), .rise_o(sdatRiseUnused), .fall_o(sdatFallUnused)
   );
   sync_edge #(.NSYNC(NSYNC)) uSyncNld (
      .clk_i(clk_i), .rst_ni(rst_ni), .async_i(nld_i),
      .level_o(nldLvlUnused), .rise_o(nldRiseUnused), .fall_o(nldFall)
   );
   sync_edge #(.NSYNC(NSYNC)) uSyncNclr (
      .clk_i(clk_i), .rst_ni(rst_ni), .async_i(nclr_i),
      .level_o(nclrLvl), .rise_o(nclrRiseUnused), .fall_o(nclrFallUnused)
   );

   assign ncsLvlUnused = ncsLvl;

   state_e          state_q;
   logic [NBIT-1:0] shift_q, shift_d;
   logic [CW-1:0]   bitCnt_q, bitCnt_d;
   logic [NBIT-1:0] ireg_q, do_q;
   logic            frmOk_q, frmErr_q, ldDone_q, busy_q;
   logic            frameGood;

   // The shift happens before the count is judged, so an SCLK rise landing
   // in the same cycle as the NCS rise still counts toward the frame.
   always_comb begin
      shift_d  = shift_q;
      bitCnt_d = bitCnt_q;
      if (sclkRise) begin
         shift_d  = {shift_q[NBIT-2:0], sdatLvl};
         bitCnt_d = (bitCnt_q == CNT_SAT) ? bitCnt_q : bitCnt_q + CW'(1);
      end
   end

   assign frameGood = (state_q == SHIFT) && ncsRise && (bitCnt_d == CNT_FULL);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         shift_q  <= '0;
         bitCnt_q <= '0;
         ireg_q   <= '0;
         do_q     <= '0;
         frmOk_q  <= 1'b0;
         frmErr_q <= 1'b0;
         ldDone_q <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         frmOk_q  <= 1'b0;
         frmErr_q <= 1'b0;
         ldDone_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (ncsFall) begin
                  shift_q  <= '0;
                  bitCnt_q <= '0;
                  state_q  <= SHIFT;
                  busy_q   <= 1'b1;
               end
            end
            SHIFT: begin
               shift_q  <= shift_d;
               bitCnt_q <= bitCnt_d;
               if (ncsRise) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  if (frameGood) begin
                     ireg_q  <= shift_d;
                     frmOk_q <= 1'b1;
                  end else begin
                     frmErr_q <= 1'b1;
                  end
               end
            end
         endcase
         // Clear dominates load; a frame finishing this cycle bypasses IREG.
         if (!nclrLvl) begin
            do_q <= '0;
         end else if (nldFall) begin
            do_q     <= frameGood ? shift_d : ireg_q;
            ldDone_q <= 1'b1;
         end
      end
   end

   assign ireg_o    = ireg_q;
   assign do_o      = do_q;
   assign frm_ok_o  = frmOk_q;
   assign frm_err_o = frmErr_q;
   assign ld_done_o = ldDone_q;
   assign busy_o    = busy_q;

endmodule

// File: tb/tb_spi_dac8512_rx.sv
// Directed bench for spi_dac8512_rx: table of frame vectors plus hand-written
// sequences for clear, load/frame collision, mid-frame reset and back-to-back.
module tb_spi_dac8512_rx;

   logic        clk = 1'b0;
   logic        rstN = 1'b0;
   logic        ncs = 1'b1;
   logic        sclk = 1'b0;
   logic        sdat = 1'b0;
   logic        nld = 1'b1;
   logic        nclr = 1'b1;
   logic [11:0] iregOut, doOut;
   logic        frmOk, frmErr, ldDone, busy;

   int assertCount = 0;
   int failCount = 0;
   int okCnt = 0, errCnt = 0, ldCnt = 0, bothCnt = 0, widthErr = 0;
   logic prevOk = 1'b0, prevErr = 1'b0, prevLd = 1'b0;

   spi_dac8512_rx #(.NBIT(12), .NSYNC(2)) dut (
      .clk_i(clk), .rst_ni(rstN), .ncs_i(ncs), .sclk_i(sclk), .sdat_i(sdat),
      .nld_i(nld), .nclr_i(nclr), .ireg_o(iregOut), .do_o(doOut),
      .frm_ok_o(frmOk), .frm_err_o(frmErr), .ld_done_o(ldDone), .busy_o(busy)
   );

   always #5 clk = ~clk;

   // Pulse monitor sampled on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (frmOk) okCnt++;
      if (frmErr) errCnt++;
      if (ldDone) ldCnt++;
      if (frmOk && ldDone) bothCnt++;
      if ((frmOk && prevOk) || (frmErr && prevErr) || (ldDone && prevLd)) widthErr++;
      prevOk  = frmOk;
      prevErr = frmErr;
      prevLd  = ldDone;
   end

   typedef struct {
      int          nbits;
      logic [15:0] data;
      bit          nclrLow;
      bit          pulseNld;
      int          expOk;
      int          expErr;
      int          expLd;
      logic [11:0] expIreg;
      logic [11:0] expDo;
   } vecT;

   vecT vecs[4];

   task automatic waitClk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic checkOutput(input string name, input int actual, input int expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic shiftBits(input logic [15:0] data, input int nbits);
      for (int b = nbits - 1; b >= 0; b--) begin
         sdat = data[b];
         waitClk(3);
         sclk = 1'b1;
         waitClk(3);
         sclk = 1'b0;
      end
      waitClk(3);
   endtask

   task automatic sendFrame(input logic [15:0] data, input int nbits);
      ncs = 1'b0;
      shiftBits(data, nbits);
      ncs = 1'b1;
   endtask

   task automatic pulseNld();
      nld = 1'b0;
      waitClk(4);
      nld = 1'b1;
      waitClk(4);
   endtask

   task automatic applyStimulus(input int idx);
      int ok0, err0, ld0;
      nclr = vecs[idx].nclrLow ? 1'b0 : 1'b1;
      waitClk(5);
      ok0 = okCnt; err0 = errCnt; ld0 = ldCnt;
      sendFrame(vecs[idx].data, vecs[idx].nbits);
      waitClk(6);
      if (vecs[idx].pulseNld) pulseNld();
      waitClk(2);
      checkOutput($sformatf("row%0d frm_ok count", idx), okCnt - ok0, vecs[idx].expOk);
      checkOutput($sformatf("row%0d frm_err count", idx), errCnt - err0, vecs[idx].expErr);
      checkOutput($sformatf("row%0d ld_done count", idx), ldCnt - ld0, vecs[idx].expLd);
      checkOutput($sformatf("row%0d IREG", idx), int'(iregOut), int'(vecs[idx].expIreg));
      checkOutput($sformatf("row%0d DO", idx), int'(doOut), int'(vecs[idx].expDo));
   endtask

   initial begin
      int ok0, err0, ld0, both0;

      vecs[0] = '{nbits: 12, data: 16'h0A5C, nclrLow: 1'b0, pulseNld: 1'b1,
                  expOk: 1, expErr: 0, expLd: 1, expIreg: 12'hA5C, expDo: 12'hA5C};
      vecs[1] = '{nbits: 11, data: 16'h07FF, nclrLow: 1'b0, pulseNld: 1'b0,
                  expOk: 0, expErr: 1, expLd: 0, expIreg: 12'hA5C, expDo: 12'hA5C};
      vecs[2] = '{nbits: 13, data: 16'h1FFF, nclrLow: 1'b0, pulseNld: 1'b0,
                  expOk: 0, expErr: 1, expLd: 0, expIreg: 12'hA5C, expDo: 12'hA5C};
      vecs[3] = '{nbits: 12, data: 16'h0123, nclrLow: 1'b1, pulseNld: 1'b1,
                  expOk: 1, expErr: 0, expLd: 0, expIreg: 12'h123, expDo: 12'h000};

      waitClk(3);
      checkOutput("reset IREG", int'(iregOut), 0);
      checkOutput("reset DO", int'(doOut), 0);
      checkOutput("reset busy", int'(busy), 0);
      checkOutput("reset pulses", int'({frmOk, frmErr, ldDone}), 0);
      rstN = 1'b1;
      waitClk(5);

      for (int i = 0; i < 4; i++) applyStimulus(i);

      // Release clear, then load the frame captured while clear was held.
      nclr = 1'b1;
      waitClk(5);
      ld0 = ldCnt;
      pulseNld();
      checkOutput("post-clear DO", int'(doOut), 12'h123);
      checkOutput("post-clear ld_done count", ldCnt - ld0, 1);

      // NLD fall lands in the same synchronized cycle as the NCS rise.
      ok0 = okCnt; ld0 = ldCnt; both0 = bothCnt;
      ncs = 1'b0;
      shiftBits(16'h0FFF, 12);
      ncs = 1'b1;
      nld = 1'b0;
      waitClk(2);
      checkOutput("busy before NCS rise seen", int'(busy), 1);
      waitClk(4);
      nld = 1'b1;
      waitClk(4);
      checkOutput("bypass DO", int'(doOut), 12'hFFF);
      checkOutput("bypass IREG", int'(iregOut), 12'hFFF);
      checkOutput("bypass coincident pulses", bothCnt - both0, 1);
      checkOutput("bypass frm_ok count", okCnt - ok0, 1);
      checkOutput("bypass ld_done count", ldCnt - ld0, 1);

      // Reset after 6 bits of a frame, then a clean frame.
      ncs = 1'b0;
      for (int b = 0; b < 6; b++) begin
         sdat = 1'b1;
         waitClk(3);
         sclk = 1'b1;
         waitClk(3);
         sclk = 1'b0;
      end
      rstN = 1'b0;
      waitClk(1);
      checkOutput("mid-frame reset IREG", int'(iregOut), 0);
      checkOutput("mid-frame reset DO", int'(doOut), 0);
      checkOutput("mid-frame reset busy", int'(busy), 0);
      checkOutput("mid-frame reset pulses", int'({frmOk, frmErr, ldDone}), 0);
      ncs = 1'b1;
      sclk = 1'b0;
      waitClk(3);
      rstN = 1'b1;
      waitClk(5);
      ok0 = okCnt; err0 = errCnt;
      sendFrame(16'h0001, 12);
      waitClk(6);
      checkOutput("after reset IREG", int'(iregOut), 12'h001);
      checkOutput("after reset frm_err count", errCnt - err0, 0);
      checkOutput("after reset frm_ok count", okCnt - ok0, 1);
      checkOutput("after reset DO", int'(doOut), 0);

      // Back-to-back frames at minimum SCLK phase with a 4 clk NCS gap.
      ok0 = okCnt; err0 = errCnt;
      sendFrame(16'h0000, 12);
      waitClk(4);
      sendFrame(16'h0FFF, 12);
      waitClk(6);
      checkOutput("back-to-back frm_ok count", okCnt - ok0, 2);
      checkOutput("back-to-back frm_err count", errCnt - err0, 0);
      checkOutput("back-to-back IREG", int'(iregOut), 12'hFFF);
      checkOutput("back-to-back busy", int'(busy), 0);

      checkOutput("pulse width violations", widthErr, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/spi_dac8512_rx.md
# spi_dac8512_rx

Receive-side counterpart of the DAC8512 SPI write path. It is clocked on the board clock and samples NCS/SCLK/SDAT/NLD/NCLR as asynchronous inputs. It reassembles 12-bit MSB-first frames and emulates the DAC8512 input and DAC register pair, including load and clear. It is used as a loopback monitor on the JA header and as a synthesizable DAC model in benches, so the DI word sent by the transmitter can be read back and shown on the display path.

## Interface
- NBIT, 12: frame length and register width.
- NSYNC, 2: synchronizer flip-flop stages per serial input (≥2).
- clk  in  1  system clock.
- NRST  in  1  asynchronous active-low reset.
- NCS  in  1  chip select, active low, async.
- SCLK  in  1  serial clock, async; data captured on rising edge.
- SDAT  in  1  serial data, MSB first, async.
- NLD  in  1  load strobe, active low, async.
- NCLR  in  1  clear, active low, async.
- IREG  out  NBIT  input register: last complete frame.
- DO  out  NBIT  DAC register: the analog output code.
- frm_ok  out  1  1-cycle pulse when IREG is updated.
- frm_err  out  1  1-cycle pulse when a frame ends with bit count ≠ NBIT.
- ld_done  out  1  1-cycle pulse when DO is loaded from IREG.
- busy  out  1  high while in SHIFT.

## Operation
- Every serial input passes through an NSYNC-stage synchronizer and then edge detect (previous-sample register).
- Edges are decided on synchronized values only.
- FSM states:
  - IDLE: waiting for an NCS falling edge. On that edge, clear the shift register and bit counter, then go to SHIFT.
  - SHIFT: on each SCLK rising edge, shift register ← {sr[NBIT-2:0], SDAT}. The counter increments and saturates at NBIT+1.
  - SHIFT exit on NCS rising edge: if count = NBIT, IREG ← sr and pulse frm_ok; otherwise IREG is unchanged and frm_err pulses. Go to IDLE.
  - SCLK edges while NCS is high are ignored.
- Load:
  - An NLD falling edge in any state gives DO ← IREG and pulses ld_done.
  - If a frame completes in the same cycle, DO takes the new frame value (same-cycle bypass).
- Clear:
  - While synchronized NCLR is low, DO = 0, and any NLD edge is ignored (no ld_done). NCLR has priority over load.
  - IREG and an in-progress frame are not affected by NCLR.
- Simultaneous SCLK rise and NCS rise in one cycle: shift first, then evaluate the count. That bit counts.
- Simultaneous NCS rise and NCS fall cannot occur, because the inputs are synchronized.
- Reset mid-frame: the partial frame is discarded and the block returns to IDLE.

## Timing
- Reset values: IREG = 0, DO = 0, frm_ok = frm_err = ld_done = busy = 0, FSM = IDLE, synchronizer stages = 1 (inactive level).
- Input-to-effect latency is NSYNC+1 clk, for example 3 clk from an NCS rise to the frm_ok pulse.
- DO updates 1 cycle after the NLD edge detect. ld_done is coincident with the new DO.
- SCLK high and low phases must each be ≥ NSYNC+1 clk periods. NCS setup to the first SCLK rise must be ≥ NSYNC+1 clk.
- The SDAT sample is taken at the synchronized SCLK rise. SDAT therefore needs to be stable from SCLK rise until NSYNC clk after it.
- All outputs are registered. Pulses are exactly 1 clk wide.

## Structure
- Package spi_dac8512_pkg holds:
  - the NBIT default;
  - the FSM state typedef {IDLE, SHIFT};
  - the counter width constant $clog2(NBIT+2).
- Sub-module sync_edge (parameter NSYNC) provides synchronizer plus rise/fall pulses. It is instantiated once per serial input: NCS, SCLK, SDAT, NLD, NCLR. For SDAT only the level is used.
- The top level holds the FSM, shift register, counter, IREG/DO registers and pulse generation.

## Test plan
- Single frame 0xA5C, NLD pulsed after NCS rise → frm_ok once, IREG = 0xA5C; then ld_done, DO = 0xA5C.
- Short frame of 11 bits, then long frame of 13 bits → frm_err pulse each time, IREG keeps its previous value 0xA5C, no frm_ok.
- NCLR held low, frame 0x123, NLD pulsed → IREG = 0x123, DO = 0, no ld_done. After NCLR rises, NLD pulse → DO = 0x123.
- NLD falling edge in the same synchronized cycle as NCS rise for frame 0xFFF → DO = 0xFFF with ld_done and frm_ok coincident.
- NRST asserted after 6 bits of a frame, released, then full frame 0x001 → all outputs 0 during reset; afterwards IREG = 0x001, no frm_err.
- Back-to-back frames at minimum SCLK phase (3 clk), 0x000 then 0xFFF, with 4 clk NCS gap → two frm_ok pulses, IREG ends at 0xFFF. Loopback from the SPI transmitter at ce10us cadence reproduces the generator samples.
